// File: rtl/riot_gen.sv
// riot_gen: 6530-style RIOT core without RAM/ROM.
// Provides NPORTS I/O ports with per-bit direction, an interval timer with four
// prescale rates, and a combined active-low interrupt.
// Optional macro RIOT_EDGE_IRQ_EN adds an edge detector on port 0 bit DATA_W-1.
module riot_gen #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cs_i,
  input  logic                     we_n_i,
  input  logic [4:0]               a_i,
  input  logic [DATA_W-1:0]        di_i,
  output logic [DATA_W-1:0]        do_o,
  output logic                     oe_o,
  input  logic [NPORTS*DATA_W-1:0] pi_i,
  output logic [NPORTS*DATA_W-1:0] po_o,
  output logic [NPORTS*DATA_W-1:0] ddr_o,
  output logic                     irq_n_o
);

  typedef logic [DATA_W-1:0] word_t;

  word_t       po_q    [NPORTS];
  word_t       po_d    [NPORTS];
  word_t       ddr_q   [NPORTS];
  word_t       ddr_d   [NPORTS];
  word_t       port_rd [NPORTS];

  word_t       timer_q, timer_d;
  logic [1:0]  sel_q, sel_d;
  logic [9:0]  psc_q, psc_d;
  logic        tflag_q, tflag_d;
  logic        tie_q, tie_d;
  word_t       do_q, do_d;
  logic        oe_q, oe_d;

  logic        eflag_s;
  logic        eirq_s;

  logic        wr, rd, port_sp, tmr_sp;
  logic [2:0]  pidx;

  assign wr      = cs_i & ~we_n_i;
  assign rd      = cs_i & we_n_i;
  assign port_sp = ~a_i[4];
  assign tmr_sp  = a_i[4] & ~a_i[3];
  assign pidx    = a_i[3:1];

  // Prescale reload value (divider minus one) for a select code.
  function automatic logic [9:0] div_m1(input logic [1:0] s);
    case (s)
      2'b00:   return 10'd0;
      2'b01:   return 10'd7;
      2'b10:   return 10'd63;
      default: return 10'd1023;
    endcase
  endfunction

  // Flatten port registers onto the buses and form per-port read values.
  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign po_o[g*DATA_W +: DATA_W]  = po_q[g];
    assign ddr_o[g*DATA_W +: DATA_W] = ddr_q[g];
    assign port_rd[g] = (ddr_q[g] & po_q[g]) | (~ddr_q[g] & pi_i[g*DATA_W +: DATA_W]);
  end

  // Port data/direction register writes; indices past NPORTS match nothing.
  always_comb begin
    for (int unsigned p = 0; p < NPORTS; p++) begin
      po_d[p]  = po_q[p];
      ddr_d[p] = ddr_q[p];
      if (wr && port_sp && pidx == 3'(p)) begin
        if (a_i[0]) ddr_d[p] = di_i;
        else        po_d[p]  = di_i;
      end
    end
  end

  // Timer next state: a write overrides the countdown; underflow wins over read-clear.
  always_comb begin
    timer_d = timer_q;
    sel_d   = sel_q;
    psc_d   = psc_q;
    tflag_d = tflag_q;
    tie_d   = tie_q;
    if (rd && tmr_sp && a_i[1:0] == 2'b00) tflag_d = 1'b0;
    if (wr && tmr_sp) begin
      timer_d = di_i;
      sel_d   = a_i[1:0];
      tie_d   = a_i[2];
      tflag_d = 1'b0;
      psc_d   = div_m1(a_i[1:0]);
    end else if (psc_q == 10'd0) begin
      timer_d = timer_q - 1'b1;
      psc_d   = div_m1(sel_q);
      if (timer_q == '0) begin
        // After underflow the timer free-runs at /1 until rewritten.
        tflag_d = 1'b1;
        sel_d   = 2'b00;
        psc_d   = 10'd0;
      end
    end else begin
      psc_d = psc_q - 10'd1;
    end
  end

`ifdef RIOT_EDGE_IRQ_EN
  logic edp_q, edp_d;
  logic eflag_q, eflag_d;
  logic epol_q, epol_d;
  logic eie_q, eie_d;
  logic edge_cur;

  assign edge_cur = port_rd[0][DATA_W-1];

  // Edge detector on port 0 MSB; a detected edge beats the status-read clear.
  always_comb begin
    edp_d   = edge_cur;
    eflag_d = eflag_q;
    epol_d  = epol_q;
    eie_d   = eie_q;
    if (rd && tmr_sp && a_i[1:0] == 2'b01) eflag_d = 1'b0;
    if (epol_q ? (~edp_q & edge_cur) : (edp_q & ~edge_cur)) eflag_d = 1'b1;
    if (wr && a_i[4] && a_i[3]) begin
      epol_d = a_i[0];
      eie_d  = a_i[1];
    end
  end

  // Edge detector state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edp_q   <= 1'b0;
      eflag_q <= 1'b0;
      epol_q  <= 1'b0;
      eie_q   <= 1'b0;
    end else begin
      edp_q   <= edp_d;
      eflag_q <= eflag_d;
      epol_q  <= epol_d;
      eie_q   <= eie_d;
    end
  end

  assign eflag_s = eflag_q;
  assign eirq_s  = eflag_q & eie_q;
`else
  assign eflag_s = 1'b0;
  assign eirq_s  = 1'b0;
`endif

  // Read data mux, registered one cycle later onto DO/OE.
  always_comb begin
    word_t rdata;
    word_t status;
    rdata  = '0;
    status = '0;
    status[DATA_W-1] = tflag_q;
    status[DATA_W-2] = eflag_s;
    if (port_sp) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (pidx == 3'(p)) rdata = a_i[0] ? ddr_q[p] : port_rd[p];
      end
    end else if (tmr_sp) begin
      case (a_i[1:0])
        2'b00:   rdata = timer_q;
        2'b01:   rdata = status;
        default: rdata = '0;
      endcase
    end
    do_d = rd ? rdata : '0;
    oe_d = rd;
  end

  // Core state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        po_q[p]  <= '0;
        ddr_q[p] <= '0;
      end
      timer_q <= '0;
      sel_q   <= 2'b00;
      psc_q   <= 10'd0;
      tflag_q <= 1'b0;
      tie_q   <= 1'b0;
      do_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        po_q[p]  <= po_d[p];
        ddr_q[p] <= ddr_d[p];
      end
      timer_q <= timer_d;
      sel_q   <= sel_d;
      psc_q   <= psc_d;
      tflag_q <= tflag_d;
      tie_q   <= tie_d;
      do_q    <= do_d;
      oe_q    <= oe_d;
    end
  end

  assign do_o    = do_q;
  assign oe_o    = oe_q;
  assign irq_n_o = ~((tflag_q & tie_q) | eirq_s);

endmodule

// File: tb/tb_riot_gen.sv
// Directed bench for riot_gen (NPORTS=2, DATA_W=8): port vector table plus
// hand-written timer, reset and edge-detector sequences.
module tb_riot_gen;

`ifdef RIOT_EDGE_IRQ_EN
  localparam bit EdgeOn = 1'b1;
`else
  localparam bit EdgeOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cs, we_n;
  logic [4:0]  a;
  logic [7:0]  di, dout;
  logic        oe, irq_n;
  logic [15:0] pi, po, ddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riot_gen #(.NPORTS(2), .DATA_W(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cs_i    (cs),
    .we_n_i  (we_n),
    .a_i     (a),
    .di_i    (di),
    .do_o    (dout),
    .oe_o    (oe),
    .pi_i    (pi),
    .po_o    (po),
    .ddr_o   (ddr),
    .irq_n_o (irq_n)
  );

  typedef struct {
    logic        c;
    logic        w;
    logic [4:0]  ad;
    logic [7:0]  d;
    logic [15:0] p;
    logic [7:0]  edo;
    logic        eoe;
    logic [15:0] epo;
    logic [15:0] eddr;
  } vec_t;

  vec_t vt [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic w, input logic [4:0] ad, input logic [7:0] d);
    @(negedge clk);
    cs = c; we_n = w; a = ad; di = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] ad, input logic [7:0] d);
    cyc(1'b1, 1'b0, ad, d);
  endtask

  task automatic rd(input logic [4:0] ad);
    cyc(1'b1, 1'b1, ad, 8'h00);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 5'd0, 8'h00);
  endtask

  initial begin
    //        cs    we_n  addr       di     pi         do     oe    po         ddr
    vt[0]  = '{1'b1, 1'b0, 5'b00001, 8'hF0, 16'h003C, 8'h00, 1'b0, 16'h0000, 16'h00F0};
    vt[1]  = '{1'b1, 1'b0, 5'b00000, 8'hA5, 16'h003C, 8'h00, 1'b0, 16'h00A5, 16'h00F0};
    vt[2]  = '{1'b1, 1'b1, 5'b00000, 8'h00, 16'h003C, 8'hAC, 1'b1, 16'h00A5, 16'h00F0};
    vt[3]  = '{1'b1, 1'b1, 5'b00001, 8'h00, 16'h003C, 8'hF0, 1'b1, 16'h00A5, 16'h00F0};
    vt[4]  = '{1'b0, 1'b1, 5'b00000, 8'h00, 16'h003C, 8'h00, 1'b0, 16'h00A5, 16'h00F0};
    vt[5]  = '{1'b1, 1'b0, 5'b01110, 8'hFF, 16'h003C, 8'h00, 1'b0, 16'h00A5, 16'h00F0};
    vt[6]  = '{1'b1, 1'b0, 5'b01111, 8'hFF, 16'h003C, 8'h00, 1'b0, 16'h00A5, 16'h00F0};
    vt[7]  = '{1'b1, 1'b1, 5'b01110, 8'h00, 16'h003C, 8'h00, 1'b1, 16'h00A5, 16'h00F0};
    vt[8]  = '{1'b0, 1'b1, 5'b00000, 8'h00, 16'h003C, 8'h00, 1'b0, 16'h00A5, 16'h00F0};
    vt[9]  = '{1'b1, 1'b0, 5'b00011, 8'h0F, 16'h003C, 8'h00, 1'b0, 16'h00A5, 16'h0FF0};
    vt[10] = '{1'b1, 1'b0, 5'b00010, 8'h3C, 16'h003C, 8'h00, 1'b0, 16'h3CA5, 16'h0FF0};
    vt[11] = '{1'b1, 1'b1, 5'b00010, 8'h00, 16'hC300, 8'hCC, 1'b1, 16'h3CA5, 16'h0FF0};
    vt[12] = '{1'b1, 1'b1, 5'b00000, 8'h00, 16'h00FF, 8'hAF, 1'b1, 16'h3CA5, 16'h0FF0};
    vt[13] = '{1'b0, 1'b0, 5'b00000, 8'h00, 16'h00FF, 8'h00, 1'b0, 16'h3CA5, 16'h0FF0};
    vt[14] = '{1'b1, 1'b1, 5'b11000, 8'h00, 16'h00FF, 8'h00, 1'b1, 16'h3CA5, 16'h0FF0};
    vt[15] = '{1'b1, 1'b1, 5'b10010, 8'h00, 16'h00FF, 8'h00, 1'b1, 16'h3CA5, 16'h0FF0};
    vt[16] = '{1'b1, 1'b1, 5'b01111, 8'h00, 16'h00FF, 8'h00, 1'b1, 16'h3CA5, 16'h0FF0};

    rst = 1'b1; cs = 1'b0; we_n = 1'b1; a = '0; di = '0; pi = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_do", dout, 8'h00);
    check("rst_oe", oe, 1'b0);
    check("rst_po", po, 16'h0000);
    check("rst_ddr", ddr, 16'h0000);
    check("rst_irq", irq_n, 1'b1);
    rst = 1'b0;

    // Port-space vectors.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      cs = vt[i].c; we_n = vt[i].w; a = vt[i].ad; di = vt[i].d; pi = vt[i].p;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_do", i), dout, vt[i].edo);
      check($sformatf("vec%0d_oe", i), oe, vt[i].eoe);
      check($sformatf("vec%0d_po", i), po, vt[i].epo);
      check($sformatf("vec%0d_ddr", i), ddr, vt[i].eddr);
    end

    // /8 countdown from 3 with IRQ enabled, through underflow.
    wr(5'b10101, 8'h03);
    for (int j = 1; j <= 32; j++) begin
      rd(5'b10100);
      check($sformatf("tmr_step%0d", j), dout, 32'(3 - (j - 1) / 8));
      if (j == 31) check("irq_pre_uflow", irq_n, 1'b1);
    end
    check("irq_uflow", irq_n, 1'b0);
    rd(5'b10001);
    check("stat_uflow", dout, 8'h80);
    check("irq_after_stat", irq_n, 1'b0);
    rd(5'b10100);
    check("tmr_fast1", dout, 8'hFE);
    check("irq_read_clr", irq_n, 1'b1);
    rd(5'b10100);
    check("tmr_fast2", dout, 8'hFD);
    rd(5'b10001);
    check("stat_clr", dout, 8'h00);

    // Write in the same cycle as a scheduled /1 decrement.
    wr(5'b10000, 8'h10);
    wr(5'b10000, 8'h55);
    rd(5'b10000);
    check("wr_beats_dec", dout, 8'h55);
    rd(5'b10000);
    check("dec_after_wr", dout, 8'h54);

    // Write in the same cycle as an underflow.
    wr(5'b10100, 8'h01);
    idle();
    wr(5'b10100, 8'h05);
    check("wr_beats_uflow_irq", irq_n, 1'b1);
    rd(5'b10001);
    check("wr_beats_uflow_stat", dout, 8'h00);
    rd(5'b10100);
    check("wr_beats_uflow_tmr", dout, 8'h04);

    // Reset in the middle of a /64 count with IRQ enabled.
    wr(5'b10110, 8'h40);
    idle();
    idle();
    @(negedge clk);
    rst = 1'b1; cs = 1'b0; pi = 16'h0000;
    @(posedge clk);
    #1;
    check("mid_rst_po", po, 16'h0000);
    check("mid_rst_ddr", ddr, 16'h0000);
    check("mid_rst_irq", irq_n, 1'b1);
    check("mid_rst_oe", oe, 1'b0);
    rst = 1'b0;
    rd(5'b10001);
    check("mid_rst_stat", dout, 8'h00);
    check("mid_rst_ie_clr", irq_n, 1'b1);
    rd(5'b10100);
    check("mid_rst_tmr", dout, 8'hFF);

    // Park the timer far from underflow, IRQ disabled.
    wr(5'b10011, 8'hFF);

    // Edge detector: rising mode, enabled.
    wr(5'b11011, 8'h00);
    idle();
    idle();
    @(negedge clk);
    cs = 1'b0; pi = 16'h0080;
    @(posedge clk);
    #1;
    check("edge_rise_irq", irq_n, EdgeOn ? 1'b0 : 1'b1);
    rd(5'b10001);
    check("edge_stat", dout, EdgeOn ? 8'h40 : 8'h00);
    check("edge_clr_irq", irq_n, 1'b1);
    @(negedge clk);
    cs = 1'b0; pi = 16'h0000;
    @(posedge clk);
    #1;
    check("edge_fall_irq", irq_n, 1'b1);
    rd(5'b10001);
    check("edge_fall_stat", dout, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
